// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the two requester ports, the shared response bus,
//               RAM port B and the statistics outputs of mem_port_arbiter.
//               slave  = arbiter side, master = requester/RAM environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [3:0]        req_we0;
    logic [3:0]        req_we1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ram_addrB;
    logic [DATA_W-1:0] ram_dinB;
    logic [3:0]        ram_web;
    logic [DATA_W-1:0] ram_doutB;
    logic [15:0]       stat_grant0;
    logic [15:0]       stat_grant1;
    logic [15:0]       stat_conflict;

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_we0, req_we1,
               req_wdata0, req_wdata1, ram_doutB,
        output req_ready, rsp_valid, rsp_rdata, ram_addrB, ram_dinB, ram_web,
               stat_grant0, stat_grant1, stat_conflict
    );

    modport master (
        output req_valid, req_addr0, req_addr1, req_we0, req_we1,
               req_wdata0, req_wdata1, ram_doutB,
        input  req_ready, rsp_valid, rsp_rdata, ram_addrB, ram_dinB, ram_web,
               stat_grant0, stat_grant1, stat_conflict
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares RAM data port B between the CPU load/store unit (port 0)
//               and the loader/debug master (port 1). Combinational grant,
//               one-cycle response routed back to the owning port.
//               RR_MODE=0: fixed priority to port 0 with MAX_BURST limit.
//               RR_MODE=1: round-robin.
//               Optional macro MEM_ARB_STATS_EN builds saturating grant and
//               conflict counters; otherwise stat_* are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 0,
    parameter int MAX_BURST = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    logic [1:0] w_grant;
    logic       r_rr_ptr;       // port that wins the next conflict (round-robin)
    logic [7:0] r_burst_cnt;    // port-0 grants while port 1 waits (fixed priority)
    logic [1:0] r_rsp_owner;    // port accepted last cycle, one-hot
    logic       r_rsp_read;     // the accepted request was a read

    // Grant decision; nothing is granted while reset is high
    always_comb begin
        w_grant = 2'b00;
        if (!reset) begin
            case (bus.req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11: begin
                    if (RR_MODE != 0)
                        w_grant = r_rr_ptr ? 2'b10 : 2'b01;
                    else
                        w_grant = (r_burst_cnt == c_max_burst) ? 2'b10 : 2'b01;
                end
                default: w_grant = 2'b00;
            endcase
        end
    end

    // Grant implies valid, so ready never rises without a request
    assign bus.req_ready = w_grant;

    // Drive RAM port B from the granted request, idle read of word 0 otherwise
    always_comb begin
        bus.ram_addrB = '0;
        bus.ram_dinB  = '0;
        bus.ram_web   = 4'b0000;
        if (w_grant[0]) begin
            bus.ram_addrB = bus.req_addr0;
            bus.ram_dinB  = bus.req_wdata0;
            bus.ram_web   = bus.req_we0;
        end else if (w_grant[1]) begin
            bus.ram_addrB = bus.req_addr1;
            bus.ram_dinB  = bus.req_wdata1;
            bus.ram_web   = bus.req_we1;
        end
    end

    // Round-robin pointer: after a grant, the other port has priority
    always_ff @(posedge clk) begin
        if (reset)
            r_rr_ptr <= 1'b0;
        else if (w_grant[0])
            r_rr_ptr <= 1'b1;
        else if (w_grant[1])
            r_rr_ptr <= 1'b0;
    end

    // Burst counter bounds how long port 1 can be starved by port 0
    always_ff @(posedge clk) begin
        if (reset)
            r_burst_cnt <= 8'd0;
        else if (w_grant[1] || !bus.req_valid[1])
            r_burst_cnt <= 8'd0;
        else if (w_grant[0])
            r_burst_cnt <= r_burst_cnt + 8'd1;
    end

    // Remember owner and read/write of the accepted request for the response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_owner <= 2'b00;
            r_rsp_read  <= 1'b0;
        end else begin
            r_rsp_owner <= w_grant;
            r_rsp_read  <= w_grant[0] ? (bus.req_we0 == 4'b0000)
                                      : (bus.req_we1 == 4'b0000);
        end
    end

    // Response is gated by reset so a request accepted just before reset is dropped
    assign bus.rsp_valid = reset ? 2'b00 : r_rsp_owner;
    assign bus.rsp_rdata = (!reset && (r_rsp_owner != 2'b00) && r_rsp_read)
                           ? bus.ram_doutB : '0;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_stat_grant0;
    logic [15:0] r_stat_grant1;
    logic [15:0] r_stat_conflict;

    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_grant0   <= 16'h0000;
            r_stat_grant1   <= 16'h0000;
            r_stat_conflict <= 16'h0000;
        end else begin
            if (w_grant[0] && (r_stat_grant0 != 16'hFFFF))
                r_stat_grant0 <= r_stat_grant0 + 16'd1;
            if (w_grant[1] && (r_stat_grant1 != 16'hFFFF))
                r_stat_grant1 <= r_stat_grant1 + 16'd1;
            if ((bus.req_valid == 2'b11) && (r_stat_conflict != 16'hFFFF))
                r_stat_conflict <= r_stat_conflict + 16'd1;
        end
    end

    assign bus.stat_grant0   = r_stat_grant0;
    assign bus.stat_grant1   = r_stat_grant1;
    assign bus.stat_conflict = r_stat_conflict;
`else
    assign bus.stat_grant0   = 16'h0000;
    assign bus.stat_grant1   = 16'h0000;
    assign bus.stat_conflict = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench. Two arbiters (fixed priority with burst
//               limit 8, and round-robin) run side by side, each with its own
//               RAM and requester state, against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_max_burst = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(0), .MAX_BURST(c_max_burst))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(1), .MAX_BURST(c_max_burst))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Reset image of the RAM; word 1 holds the known instruction 0x00739393
    function automatic logic [31:0] img(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 1) ? 32'h0073_9393 : {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // RAM environment: registered read, byte write enables, reloaded during reset
    logic [31:0] ram [2][256];
    logic [31:0] dout [2];
    assign bus0.ram_doutB = dout[0];
    assign bus1.ram_doutB = dout[1];

    // Behavioural RAM port B for both DUTs
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                ram[0][i] <= img(i);
                ram[1][i] <= img(i);
            end
            dout[0] <= 32'h0;
            dout[1] <= 32'h0;
        end else begin
            dout[0] <= ram[0][bus0.ram_addrB[9:2]];
            dout[1] <= ram[1][bus1.ram_addrB[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (bus0.ram_web[b]) ram[0][bus0.ram_addrB[9:2]][8*b +: 8] <= bus0.ram_dinB[8*b +: 8];
                if (bus1.ram_web[b]) ram[1][bus1.ram_addrB[9:2]][8*b +: 8] <= bus1.ram_dinB[8*b +: 8];
            end
        end
    end

    // ---------------- requester state ----------------
    logic [1:0]  pend   [2];
    logic [31:0] paddr  [2][2];
    logic [3:0]  pwe    [2][2];
    logic [31:0] pwdata [2][2];
    logic [1:0]  acc    [2];
    int          rate;

    // ---------------- reference model state ----------------
    logic [31:0] mmem [2][256];
    logic        prio [2];        // round-robin: port favoured on next conflict
    int          streak [2];      // fixed priority: port-0 wins while port 1 waits
    int          p1wait [2];
    logic [1:0]  exp_rv [2];
    logic [31:0] exp_rd [2];
    logic [15:0] cnt_g0 [2];
    logic [15:0] cnt_g1 [2];
    logic [15:0] cnt_cf [2];
    logic [63:0] hist [2];
    int          hcnt [2];
    logic        stats_on;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  ready;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  web;
        logic [1:0]  rv;
        logic [31:0] rd;
        logic [15:0] sg0;
        logic [15:0] sg1;
        logic [15:0] sc;
    } obs_t;

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.ready = bus0.req_ready; o.addr = bus0.ram_addrB; o.din = bus0.ram_dinB;
            o.web = bus0.ram_web; o.rv = bus0.rsp_valid; o.rd = bus0.rsp_rdata;
            o.sg0 = bus0.stat_grant0; o.sg1 = bus0.stat_grant1; o.sc = bus0.stat_conflict;
        end else begin
            o.ready = bus1.req_ready; o.addr = bus1.ram_addrB; o.din = bus1.ram_dinB;
            o.web = bus1.ram_web; o.rv = bus1.rsp_valid; o.rd = bus1.rsp_rdata;
            o.sg0 = bus1.stat_grant0; o.sg1 = bus1.stat_grant1; o.sc = bus1.stat_conflict;
        end
        return o;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    task automatic model_reset(input int d);
        for (int i = 0; i < 256; i++) mmem[d][i] = img(i);
        prio[d] = 1'b0; streak[d] = 0; p1wait[d] = 0;
        exp_rv[d] = 2'b00; exp_rd[d] = 32'h0;
        cnt_g0[d] = 16'h0; cnt_g1[d] = 16'h0; cnt_cf[d] = 16'h0;
    endtask

    task automatic put(input int d, input int p, input logic [31:0] a,
                       input logic [3:0] we, input logic [31:0] wd);
        pend[d][p] = 1'b1; paddr[d][p] = a; pwe[d][p] = we; pwdata[d][p] = wd;
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (!pend[d][p] && ($urandom_range(99) < rate))
                    put(d, p, {22'h0, 8'($urandom_range(63)), 2'b00},
                        ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0, $urandom);
        bus0.req_valid = pend[0];
        bus0.req_addr0 = paddr[0][0]; bus0.req_we0 = pwe[0][0]; bus0.req_wdata0 = pwdata[0][0];
        bus0.req_addr1 = paddr[0][1]; bus0.req_we1 = pwe[0][1]; bus0.req_wdata1 = pwdata[0][1];
        bus1.req_valid = pend[1];
        bus1.req_addr0 = paddr[1][0]; bus1.req_we0 = pwe[1][0]; bus1.req_wdata0 = pwdata[1][0];
        bus1.req_addr1 = paddr[1][1]; bus1.req_we1 = pwe[1][1]; bus1.req_wdata1 = pwdata[1][1];
    endtask

    // Compare one DUT against the model mid-cycle, then advance the model
    task automatic eval(input int d);
        obs_t        o;
        logic [1:0]  v, g;
        int          p, idx, lim;
        o = sample(d);
        v = pend[d];
        g = 2'b00;
        if (!reset) begin
            if (v == 2'b01)      g = 2'b01;
            else if (v == 2'b10) g = 2'b10;
            else if (v == 2'b11) begin
                if (d == 1) g = prio[d] ? 2'b10 : 2'b01;
                else        g = (streak[d] == c_max_burst) ? 2'b10 : 2'b01;
            end
        end
        p = g[1] ? 1 : 0;
        check_eq("req_ready", 64'(o.ready), 64'(g));
        check_eq("ram_addrB", 64'(o.addr), (g != 0) ? 64'(paddr[d][p]) : 64'h0);
        check_eq("ram_dinB",  64'(o.din),  (g != 0) ? 64'(pwdata[d][p]) : 64'h0);
        check_eq("ram_web",   64'(o.web),  (g != 0) ? 64'(pwe[d][p]) : 64'h0);
        check_eq("rsp_valid", 64'(o.rv), reset ? 64'h0 : 64'(exp_rv[d]));
        check_eq("rsp_rdata", 64'(o.rd), reset ? 64'h0 : 64'(exp_rd[d]));
        check_eq("stat_grant0",   64'(o.sg0), stats_on ? 64'(cnt_g0[d]) : 64'h0);
        check_eq("stat_grant1",   64'(o.sg1), stats_on ? 64'(cnt_g1[d]) : 64'h0);
        check_eq("stat_conflict", 64'(o.sc),  stats_on ? 64'(cnt_cf[d]) : 64'h0);
        hist[d] = hist[d] | (64'(o.ready[1]) << hcnt[d]);
        hcnt[d]++;
        acc[d] = o.ready & pend[d];
        if (reset) begin
            model_reset(d);
        end else begin
            exp_rv[d] = g;
            exp_rd[d] = 32'h0;
            if (g != 0) begin
                idx = int'(paddr[d][p][9:2]);
                if (pwe[d][p] == 4'h0)
                    exp_rd[d] = mmem[d][idx];
                else
                    for (int b = 0; b < 4; b++)
                        if (pwe[d][p][b]) mmem[d][idx][8*b +: 8] = pwdata[d][p][8*b +: 8];
            end
            if (g[0]) prio[d] = 1'b1;
            if (g[1]) prio[d] = 1'b0;
            if (g[1] || !v[1]) streak[d] = 0;
            else if (g[0])     streak[d]++;
            if (g[0]) cnt_g0[d] = sat_inc(cnt_g0[d]);
            if (g[1]) cnt_g1[d] = sat_inc(cnt_g1[d]);
            if (v == 2'b11) cnt_cf[d] = sat_inc(cnt_cf[d]);
            lim = (d == 0) ? c_max_burst : 1;
            if (o.ready[1]) begin
                check_eq("p1_wait_bound", 64'(p1wait[d] <= lim), 64'h1);
                p1wait[d] = 0;
            end else if (v[1]) p1wait[d]++;
            else p1wait[d] = 0;
        end
    endtask

    // One clock: drive after the edge, check at the falling edge
    task automatic cycle();
        drive();
        @(negedge clk);
        eval(0);
        eval(1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) pend[d] = pend[d] & ~acc[d];
    endtask

    task automatic clear_hist();
        for (int d = 0; d < 2; d++) begin hist[d] = 64'h0; hcnt[d] = 0; end
    endtask

    initial begin
`ifdef MEM_ARB_STATS_EN
        stats_on = 1'b1;
`else
        stats_on = 1'b0;
`endif
        rate = 0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 2'b00; acc[d] = 2'b00;
            for (int p = 0; p < 2; p++) begin
                paddr[d][p] = 32'h0; pwe[d][p] = 4'h0; pwdata[d][p] = 32'h0;
            end
            model_reset(d);
        end
        clear_hist();
        drive();
        repeat (2) @(posedge clk);
        #1;
        repeat (2) cycle();
        reset = 1'b0;

        // Port 0 read of word 1 straight after reset
        put(0, 0, 32'h4, 4'h0, 32'h0);
        put(1, 0, 32'h4, 4'h0, 32'h0);
        cycle();
        check_eq("t1_rsp_valid0", 64'(bus0.rsp_valid), 64'h1);
        check_eq("t1_rdata0",     64'(bus0.rsp_rdata), 64'h0073_9393);
        check_eq("t1_rdata1",     64'(bus1.rsp_rdata), 64'h0073_9393);

        // Port 1 full-word write, then port 0 read of the same word
        put(0, 1, 32'h100, 4'hF, 32'hDEAD_BEEF);
        put(1, 1, 32'h100, 4'hF, 32'hDEAD_BEEF);
        cycle();
        check_eq("t2_wr_rsp_valid", 64'(bus0.rsp_valid), 64'h2);
        check_eq("t2_wr_rdata",     64'(bus0.rsp_rdata), 64'h0);
        put(0, 0, 32'h100, 4'h0, 32'h0);
        put(1, 0, 32'h100, 4'h0, 32'h0);
        cycle();
        check_eq("t2_rd_rsp_valid", 64'(bus1.rsp_valid), 64'h1);
        check_eq("t2_rd_rdata",     64'(bus0.rsp_rdata), 64'hDEAD_BEEF);
        cycle();

        // Continuous conflict from a fresh reset: RR alternates, fixed gives 8:1
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rate = 100;
        clear_hist();
        repeat (20) cycle();
        check_eq("t3_rr_pattern",    64'(hist[1][5:0]),  64'h2A);
        check_eq("t4_burst_pattern", 64'(hist[0][19:0]), 64'h20100);

        // Reset the cycle after a port-0 read is accepted
        rate = 0;
        repeat (3) cycle();
        pend[0] = 2'b00; pend[1] = 2'b00;
        put(0, 0, 32'h8, 4'h0, 32'h0);
        put(1, 0, 32'h8, 4'h0, 32'h0);
        cycle();
        reset = 1'b1;
        #1;
        check_eq("t5_rsp_dropped0", 64'(bus0.rsp_valid), 64'h0);
        check_eq("t5_rsp_dropped1", 64'(bus1.rsp_valid), 64'h0);
        repeat (2) cycle();
        check_eq("t5_stat_conflict", 64'(bus0.stat_conflict), 64'h0);
        check_eq("t5_stat_grant0",   64'(bus1.stat_grant0), 64'h0);
        reset = 1'b0;

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rate = $urandom_range(100);
            if (reset) reset = ($urandom_range(1) == 1);
            else       reset = ($urandom_range(99) == 0);
            cycle();
        end
        reset = 1'b0;

`ifdef MEM_ARB_STATS_EN
        // Long conflict run drives the conflict counter into saturation
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rate = 100;
        repeat (70000) cycle();
        check_eq("t6_conflict_sat", 64'(bus0.stat_conflict), 64'hFFFF);
`endif
        rate = 0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
